// File: rtl/timer_bank_pkg.sv
// Shared constants and types for the memory-mapped timer bank.
package timer_bank_pkg;

  // Peripheral window base in the LSU address space (16-byte aligned).
  localparam logic [31:0] TIMER_BASE_ADDR = 32'h4000_1000;

  // Register offsets within one 16-byte channel window.
  localparam logic [3:0] TMR_CTRL_OFS   = 4'h0;
  localparam logic [3:0] TMR_COUNT_OFS  = 4'h4;
  localparam logic [3:0] TMR_CMP_OFS    = 4'h8;
  localparam logic [3:0] TMR_STATUS_OFS = 4'hC;

  // STATUS bit positions.
  localparam int unsigned TMR_MATCH_BIT = 0;
  localparam int unsigned TMR_OVF_BIT   = 1;

  typedef struct packed {
    logic [7:0] psc;
    logic       ie;
    logic       auto;
    logic       en;
  } TmrCtrl_s;

  // Place CTRL fields at their bus bit positions; unused bits read 0.
  function automatic logic [31:0] tmr_ctrl_pack(input TmrCtrl_s c);
    return {16'h0000, c.psc, 5'b00000, c.ie, c.auto, c.en};
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One up-counting timer channel: CTRL/COUNT/CMP/STATUS plus optional prescaler.
// Optional feature macro: TIMER_BANK_PRESCALER_EN.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [3:0]  wofs_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  rofs_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic             en_q, en_d, auto_q, auto_d, ie_q, ie_d;
  logic             match_q, match_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d, cmp_q, cmp_d;
  logic             tick;
  logic             wr_ctrl, wr_count, wr_cmp, wr_status;
  logic [7:0]       psc_val;
  TmrCtrl_s         ctrl_rd;
  logic             unused_wdata;

  assign wr_ctrl   = we_i && (wofs_i == TMR_CTRL_OFS);
  assign wr_count  = we_i && (wofs_i == TMR_COUNT_OFS);
  assign wr_cmp    = we_i && (wofs_i == TMR_CMP_OFS);
  assign wr_status = we_i && (wofs_i == TMR_STATUS_OFS);

  // Upper store bits are irrelevant for narrow counters.
  assign unused_wdata = ^wdata_i;

`ifdef TIMER_BANK_PRESCALER_EN
  logic [7:0] psc_q, psc_d, pcnt_q, pcnt_d;

  // Prescaler: tick when the divider reaches PSC; any CTRL write restarts it.
  always_comb begin
    tick   = en_q && (pcnt_q == psc_q);
    psc_d  = psc_q;
    pcnt_d = pcnt_q;
    if (en_q) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    if (wr_ctrl) begin
      psc_d  = wdata_i[15:8];
      pcnt_d = 8'd0;
    end
  end

  // Prescaler state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psc_q  <= 8'd0;
      pcnt_q <= 8'd0;
    end else begin
      psc_q  <= psc_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign psc_val = psc_q;
`else
  assign tick    = en_q;
  assign psc_val = 8'd0;
`endif

  // Next state: counter events first, then bus writes override; STATUS sets beat W1C clears.
  always_comb begin
    en_d    = en_q;
    auto_d  = auto_q;
    ie_d    = ie_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    ovf_d   = ovf_q;
    if (wr_status) begin
      if (wdata_i[TMR_MATCH_BIT]) match_d = 1'b0;
      if (wdata_i[TMR_OVF_BIT])   ovf_d   = 1'b0;
    end
    if (tick) begin
      if (count_q == cmp_q) begin
        match_d = 1'b1;
        if (auto_q) count_d = '0;
        else        en_d    = 1'b0;
      end else if (count_q == {CNT_W{1'b1}}) begin
        ovf_d   = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
    if (wr_count) count_d = wdata_i[CNT_W-1:0];
    if (wr_cmp)   cmp_d   = wdata_i[CNT_W-1:0];
    if (wr_ctrl) begin
      en_d   = wdata_i[0];
      auto_d = wdata_i[1];
      ie_d   = wdata_i[2];
    end
  end

  // Channel registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      count_q <= '0;
      cmp_q   <= {CNT_W{1'b1}};
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

  // Register read-back, zero-extended to the bus width.
  always_comb begin
    ctrl_rd = '{psc: psc_val, ie: ie_q, auto: auto_q, en: en_q};
    rdata_o = '0;
    case (rofs_i)
      TMR_CTRL_OFS:  rdata_o = tmr_ctrl_pack(ctrl_rd);
      TMR_COUNT_OFS: rdata_o = 32'(count_q);
      TMR_CMP_OFS:   rdata_o = 32'(cmp_q);
      TMR_STATUS_OFS: begin
        rdata_o[TMR_MATCH_BIT] = match_q;
        rdata_o[TMR_OVF_BIT]   = ovf_q;
      end
      default:       rdata_o = '0;
    endcase
  end

  assign irq_o = match_q & ie_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_TIMERS memory-mapped timers: address decode, write steering and read mux.
// Optional feature macro: TIMER_BANK_PRESCALER_EN (handled inside timer_channel).
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned NUM_TIMERS = 4,
  parameter int unsigned CNT_W      = 32,
  parameter logic [31:0] BASE_ADDR  = TIMER_BASE_ADDR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  wen_i,
  output logic [31:0]           rdata_o,
  output logic [NUM_TIMERS-1:0] irq_o,
  output logic                  irq_any_o
);

  localparam logic [31:0] WinBytes = 32'(16 * NUM_TIMERS);

  logic [31:0] off;
  logic        hit;
  logic [3:0]  ch_sel;
  logic [3:0]  reg_ofs;
  logic [31:0] ch_rdata [NUM_TIMERS];

  // Offset arithmetic avoids overflow when the window sits near the top of memory.
  assign off     = addr_i - BASE_ADDR;
  assign hit     = (addr_i >= BASE_ADDR) && (off < WinBytes);
  assign ch_sel  = off[7:4];
  assign reg_ofs = {off[3:2], 2'b00};

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .we_i   (wen_i && hit && (ch_sel == 4'(g))),
      .wofs_i (reg_ofs),
      .wdata_i(wdata_i),
      .rofs_i (reg_ofs),
      .rdata_o(ch_rdata[g]),
      .irq_o  (irq_o[g])
    );
  end

  // Read mux: selected channel's register, 0 outside the window.
  always_comb begin
    rdata_o = '0;
    if (hit) begin
      for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
        if (ch_sel == 4'(i)) rdata_o = ch_rdata[i];
      end
    end
  end

  assign irq_any_o = |irq_o;

endmodule
